// File: rtl/spike_filter_pkg.sv
// Shared definitions for the spike filter scheduler: config addresses, FSM states, overrun width.
package spike_filter_pkg;

  localparam logic [1:0] CFG_PERIOD     = 2'd0;
  localparam logic [1:0] CFG_FILTS_USED = 2'd1;
  localparam logic [1:0] CFG_INC        = 2'd2;
  localparam logic [1:0] CFG_DECAY      = 2'd3;

  localparam int OVR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SWEEP,
    GRANT
  } state_t;

endpackage

// File: rtl/spike_filter_prescaler.sv
// Update-period prescaler: owns the period register, raises pend on each tick.
// Overrun counting is present only when SPIKE_FILTER_OVERRUN_CNT_EN is defined.
module spike_filter_prescaler
  import spike_filter_pkg::*;
#(
  parameter int Nprescale = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 period_wr,
  input  logic [Nprescale-1:0] period_data,
  input  logic                 pend_clr,
  output logic                 pend,
  output logic [OVR_W-1:0]     overrun_cnt
);

  logic [Nprescale-1:0] period_reg;
  logic [Nprescale-1:0] count_reg;
  logic                 pend_reg;
  logic                 tick;

  assign tick = (period_reg != '0) && (count_reg == period_reg - Nprescale'(1));
  assign pend = pend_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_reg <= '0;
      count_reg  <= '0;
      pend_reg   <= 1'b0;
    end else begin
      if (period_wr) begin
        period_reg <= period_data;
        count_reg  <= '0;
      end else if (tick || period_reg == '0) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + Nprescale'(1);
      end
      // A tick landing on the clearing cycle re-arms pend rather than being lost.
      pend_reg <= tick | (pend_reg & ~pend_clr);
    end
  end

`ifdef SPIKE_FILTER_OVERRUN_CNT_EN
  logic [OVR_W-1:0] overrun_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_reg <= '0;
    end else if (tick && pend_reg && !pend_clr && overrun_reg != '1) begin
      overrun_reg <= overrun_reg + OVR_W'(1);
    end
  end

  assign overrun_cnt = overrun_reg;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: rtl/spike_filter_scheduler.sv
// Sequences the shared spike filter array: update pulses, round-robin tag arbitration, config.
// Define SPIKE_FILTER_OVERRUN_CNT_EN to implement the missed-tick counter.
module spike_filter_scheduler
  import spike_filter_pkg::*;
#(
  parameter int Nfilts    = 10,
  parameter int Nct       = 10,
  parameter int Nstate    = 27,
  parameter int Nprescale = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_data,
  input  logic [Nfilts-1:0] src0_tag,
  input  logic [Nct-1:0]    src0_ct,
  input  logic              src0_v,
  output logic              src0_a,
  input  logic [Nfilts-1:0] src1_tag,
  input  logic [Nct-1:0]    src1_ct,
  input  logic              src1_v,
  output logic              src1_a,
  output logic [Nfilts-1:0] arr_tag,
  output logic [Nct-1:0]    arr_ct,
  output logic              arr_v,
  input  logic              arr_a,
  input  logic              arr_idle,
  output logic              update_pulse,
  output logic [Nfilts-1:0] filts_used,
  output logic [Nstate-1:0] increment_constant,
  output logic [Nstate-1:0] decay_constant,
  output logic [15:0]       overrun_cnt
);

  state_t            state_reg;
  logic              grant_reg;
  logic              rr_reg;
  logic              update_pulse_reg;
  logic              arr_v_reg;
  logic [Nfilts-1:0] filts_used_reg;
  logic [Nstate-1:0] increment_reg;
  logic [Nstate-1:0] decay_reg;
  logic              pend;
  logic              pend_clr;
  logic              cfg_unused;

  assign cfg_unused = ^cfg_data[31:Nstate];
  assign pend_clr   = (state_reg == IDLE) && pend && arr_idle;

  spike_filter_prescaler #(
    .Nprescale(Nprescale)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .period_wr  (cfg_wr && cfg_addr == CFG_PERIOD),
    .period_data(cfg_data[Nprescale-1:0]),
    .pend_clr   (pend_clr),
    .pend       (pend),
    .overrun_cnt(overrun_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filts_used_reg <= '0;
      increment_reg  <= '0;
      decay_reg      <= '0;
    end else if (cfg_wr) begin
      case (cfg_addr)
        CFG_FILTS_USED: filts_used_reg <= cfg_data[Nfilts-1:0];
        CFG_INC:        increment_reg  <= cfg_data[Nstate-1:0];
        CFG_DECAY:      decay_reg      <= cfg_data[Nstate-1:0];
        default:        ;
      endcase
    end
  end

  // Updates win over tags so a pending pulse never waits behind a stream of transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      grant_reg        <= 1'b0;
      rr_reg           <= 1'b0;
      update_pulse_reg <= 1'b0;
      arr_v_reg        <= 1'b0;
    end else begin
      update_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pend && arr_idle) begin
            state_reg        <= PULSE;
            update_pulse_reg <= 1'b1;
          end else if ((src0_v || src1_v) && arr_idle) begin
            state_reg <= GRANT;
            arr_v_reg <= 1'b1;
            grant_reg <= (src0_v && src1_v) ? rr_reg : src1_v;
          end
        end
        PULSE: state_reg <= SWEEP;
        SWEEP: if (arr_idle) state_reg <= IDLE;
        GRANT: begin
          if (arr_a) begin
            arr_v_reg <= 1'b0;
            rr_reg    <= ~grant_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign update_pulse       = update_pulse_reg;
  assign arr_v              = arr_v_reg;
  assign arr_tag            = arr_v_reg ? (grant_reg ? src1_tag : src0_tag) : '0;
  assign arr_ct             = arr_v_reg ? (grant_reg ? src1_ct : src0_ct) : '0;
  assign src0_a             = arr_v_reg & arr_a & ~grant_reg;
  assign src1_a             = arr_v_reg & arr_a & grant_reg;
  assign filts_used         = filts_used_reg;
  assign increment_constant = increment_reg;
  assign decay_constant     = decay_reg;

  // A granted source must keep offering until its acknowledge.
  src_hold: assert property (@(posedge clk) disable iff (!reset)
    (arr_v_reg && !arr_a) |=> (grant_reg ? src1_v : src0_v));

endmodule

// File: tb/tb_spike_filter_scheduler.sv
// Self-checking bench for spike_filter_scheduler: config table, directed corner cases,
// then randomized traffic against a cycle reference model. Honours SPIKE_FILTER_OVERRUN_CNT_EN.
module tb_spike_filter_scheduler;

  localparam int NF = 10, NC = 10, NS = 27;
  localparam int FREE = 0, PULSING = 1, SWEEPING = 2, SERVING = 3;
`ifdef SPIKE_FILTER_OVERRUN_CNT_EN
  localparam int OVR_EXP = 2;
`else
  localparam int OVR_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [31:0]   cfg_data = 32'd0;
  logic [NF-1:0] src0_tag = '0, src1_tag = '0;
  logic [NC-1:0] src0_ct = '0, src1_ct = '0;
  logic          src0_v = 1'b0, src1_v = 1'b0;
  logic          src0_a, src1_a;
  logic [NF-1:0] arr_tag;
  logic [NC-1:0] arr_ct;
  logic          arr_v;
  logic          arr_a = 1'b0, arr_idle = 1'b1;
  logic          update_pulse;
  logic [NF-1:0] filts_used;
  logic [NS-1:0] increment_constant, decay_constant;
  logic [15:0]   overrun_cnt;

  always #5 clk = ~clk;

  spike_filter_scheduler dut (
    .clk(clk), .reset(reset),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .src0_tag(src0_tag), .src0_ct(src0_ct), .src0_v(src0_v), .src0_a(src0_a),
    .src1_tag(src1_tag), .src1_ct(src1_ct), .src1_v(src1_v), .src1_a(src1_a),
    .arr_tag(arr_tag), .arr_ct(arr_ct), .arr_v(arr_v), .arr_a(arr_a), .arr_idle(arr_idle),
    .update_pulse(update_pulse), .filts_used(filts_used),
    .increment_constant(increment_constant), .decay_constant(decay_constant),
    .overrun_cnt(overrun_cnt)
  );

  int total = 0, bad = 0, cyc = 0;

  // Reference model: prescaler kept as "cycles left until tick", scheduler as an activity mode.
  int m_period, m_left, m_ovr, m_mode, m_who, m_rr, m_fu, m_inc, m_dec;
  bit m_pend;
  bit e_a0, e_a1;
  bit o_pulse, o_v, o_a0, o_a1;
  logic [NF-1:0] o_tag;
  logic [15:0] o_ovr;
  int o_cyc;

  typedef struct {
    logic [1:0]    addr;
    logic [31:0]   data;
    logic [NF-1:0] fu;
    logic [NS-1:0] inc;
    logic [NS-1:0] dec;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_period = 0; m_left = 0; m_ovr = 0; m_pend = 0;
    m_mode = FREE; m_who = 0; m_rr = 0;
    m_fu = 0; m_inc = 0; m_dec = 0;
  endtask

  // One clock cycle: inputs already applied; check outputs, advance model, move to next negedge.
  task automatic step();
    bit e_pulse, e_v, tick, take;
    logic [63:0] e_tag, e_ct;
    e_pulse = (m_mode == PULSING);
    e_v     = (m_mode == SERVING);
    e_tag = 0; e_ct = 0;
    if (e_v) begin
      e_tag = (m_who == 1) ? src1_tag : src0_tag;
      e_ct  = (m_who == 1) ? src1_ct : src0_ct;
    end
    e_a0 = e_v && arr_a && (m_who == 0);
    e_a1 = e_v && arr_a && (m_who == 1);
    #1;
    chk("update_pulse", update_pulse, e_pulse);
    chk("arr_v", arr_v, e_v);
    chk("arr_tag", arr_tag, e_tag);
    chk("arr_ct", arr_ct, e_ct);
    chk("src0_a", src0_a, e_a0);
    chk("src1_a", src1_a, e_a1);
    chk("filts_used", filts_used, m_fu);
    chk("increment_constant", increment_constant, m_inc);
    chk("decay_constant", decay_constant, m_dec);
    chk("overrun_cnt", overrun_cnt, m_ovr);
    chk("pulse_with_valid", update_pulse & arr_v, 0);
    o_pulse = update_pulse; o_v = arr_v; o_a0 = src0_a; o_a1 = src1_a;
    o_tag = arr_tag; o_ovr = overrun_cnt; o_cyc = cyc;
    if (src0_a || src1_a)
      $display("xfer cyc=%0d src=%0d tag=%0h ct=%0h", cyc, src1_a, arr_tag, arr_ct);

    tick = (m_period != 0) && (m_left == 1);
    take = (m_mode == FREE) && m_pend && arr_idle;
`ifdef SPIKE_FILTER_OVERRUN_CNT_EN
    if (tick && m_pend && !take && m_ovr < 65535) m_ovr++;
`endif
    m_pend = tick || (m_pend && !take);
    if (cfg_wr && cfg_addr == 2'd0) begin
      m_period = int'(cfg_data & 32'hFFFF);
      m_left   = m_period;
    end else if (tick) begin
      m_left = m_period;
    end else if (m_period != 0) begin
      m_left--;
    end
    if (cfg_wr && cfg_addr == 2'd1) m_fu  = int'(cfg_data & 32'h3FF);
    if (cfg_wr && cfg_addr == 2'd2) m_inc = int'(cfg_data & 32'h7FF_FFFF);
    if (cfg_wr && cfg_addr == 2'd3) m_dec = int'(cfg_data & 32'h7FF_FFFF);
    case (m_mode)
      FREE: begin
        if (take) m_mode = PULSING;
        else if ((src0_v || src1_v) && arr_idle) begin
          m_mode = SERVING;
          m_who  = (src0_v && src1_v) ? m_rr : (src1_v ? 1 : 0);
        end
      end
      PULSING:  m_mode = SWEEPING;
      SWEEPING: if (arr_idle) m_mode = FREE;
      default: begin
        if (arr_a) begin
          m_rr   = 1 - m_who;
          m_mode = FREE;
        end
      end
    endcase
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cfg_wr = 1'b0;
    #1;
    chk("rst_arr_v", arr_v, 0);
    chk("rst_update_pulse", update_pulse, 0);
    chk("rst_arr_tag", arr_tag, 0);
    chk("rst_arr_ct", arr_ct, 0);
    chk("rst_src_a", {src0_a, src1_a}, 0);
    chk("rst_filts_used", filts_used, 0);
    chk("rst_increment", increment_constant, 0);
    chk("rst_decay", decay_constant, 0);
    chk("rst_overrun", overrun_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w, w2, np, nx, prev, pc, vc, age;
    bit found, serving;
    int exp_tags[4];
    exp_tags = '{3, 7, 3, 7};

    vecs[0] = '{2'd1, 32'h0000_0155, 10'h155, 27'h0,        27'h0};
    vecs[1] = '{2'd2, 32'hFFFF_FFFF, 10'h155, 27'h7FF_FFFF, 27'h0};
    vecs[2] = '{2'd3, 32'h1234_5678, 10'h155, 27'h7FF_FFFF, 27'h234_5678};
    vecs[3] = '{2'd1, 32'hABCD_E000, 10'h000, 27'h7FF_FFFF, 27'h234_5678};
    vecs[4] = '{2'd2, 32'h0000_0001, 10'h000, 27'h1,        27'h234_5678};
    vecs[5] = '{2'd3, 32'hFFFF_FFFF, 10'h000, 27'h1,        27'h7FF_FFFF};
    vecs[6] = '{2'd0, 32'h0000_0000, 10'h000, 27'h1,        27'h7FF_FFFF};

    @(negedge clk);
    apply_reset();

    // Config register table
    for (int i = 0; i < 7; i++) begin
      cfg(vecs[i].addr, vecs[i].data);
      chk("vec_filts_used", filts_used, vecs[i].fu);
      chk("vec_increment", increment_constant, vecs[i].inc);
      chk("vec_decay", decay_constant, vecs[i].dec);
      $display("cfg vec %0d addr=%0d data=%08h", i, vecs[i].addr, vecs[i].data);
    end
    step();

    // Periodic pulses, P=4
    apply_reset();
    arr_idle = 1'b1;
    w = cyc;
    cfg(2'd0, 32'd4);
    np = 0; prev = -1;
    repeat (24) begin
      step();
      if (o_pulse) begin
        np++;
        if (prev >= 0) chk("p4_gap", o_cyc - prev, 4);
        else chk("p4_first", o_cyc - w, 6);
        prev = o_cyc;
      end
    end
    chk("p4_count", np, 5);
    chk("p4_overrun", o_ovr, 0);
    $display("periodic test pulses=%0d", np);

    // Round-robin with both sources held, ack 2 cycles after valid
    apply_reset();
    arr_idle = 1'b1;
    src0_v = 1'b1; src0_tag = 10'd3; src0_ct = 10'd11;
    src1_v = 1'b1; src1_tag = 10'd7; src1_ct = 10'd22;
    age = 0; nx = 0;
    for (int i = 0; i < 60 && nx < 4; i++) begin
      serving = (m_mode == SERVING);
      arr_a = serving && (age == 2);
      step();
      age = (serving && !arr_a) ? age + 1 : 0;
      if (o_a0 || o_a1) begin
        chk("rr_tag", o_tag, exp_tags[nx]);
        chk("rr_src", o_a1, nx % 2);
        nx++;
      end
    end
    chk("rr_done", nx, 4);
    arr_a = 1'b0; src0_v = 1'b0; src1_v = 1'b0;
    step();

    // Array busy across several ticks
    apply_reset();
    arr_idle = 1'b1;
    cfg(2'd0, 32'd4);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = o_pulse;
    end
    chk("ov_first_pulse", found, 1);
    arr_idle = 1'b0; np = 0;
    repeat (10) begin step(); np += int'(o_pulse); end
    chk("ov_hold_pulses", np, 0);
    arr_idle = 1'b1; np = 0;
    repeat (4) begin step(); np += int'(o_pulse); end
    chk("ov_resume_pulses", np, 1);
    chk("ov_count", o_ovr, OVR_EXP);
    $display("overrun test overrun=%0d", o_ovr);

    // Pending update and src0 request together: pulse first, then grant
    apply_reset();
    arr_idle = 1'b1;
    w = cyc;
    cfg(2'd0, 32'd16);
    repeat (16) step();
    src0_v = 1'b1; src0_tag = 10'd5; src0_ct = 10'd9;
    pc = -1; vc = -1;
    for (int i = 0; i < 12 && vc < 0; i++) begin
      step();
      if (o_pulse && pc < 0) pc = o_cyc;
      if (o_v && vc < 0) begin
        vc = o_cyc;
        chk("coin_tag", o_tag, 5);
      end
    end
    chk("coin_pulse_at", pc - w, 18);
    chk("coin_grant_at", vc - w, 21);
    arr_a = 1'b1;
    step();
    chk("coin_ack", o_a0, 1);
    arr_a = 1'b0; src0_v = 1'b0;
    $display("coincidence test pulse=%0d grant=%0d", pc - w, vc - w);

    // Period rewrite mid-count restarts the count
    apply_reset();
    arr_idle = 1'b1;
    cfg(2'd0, 32'd16);
    repeat (5) step();
    w2 = cyc;
    cfg(2'd0, 32'd8);
    pc = -1;
    for (int i = 0; i < 14 && pc < 0; i++) begin
      step();
      if (o_pulse) pc = o_cyc;
    end
    chk("rewrite_pulse_at", pc - w2, 10);
    $display("rewrite test pulse=%0d", pc - w2);

    // Reset during GRANT
    apply_reset();
    arr_idle = 1'b1; arr_a = 1'b0;
    src0_v = 1'b1; src0_tag = 10'd9; src0_ct = 10'd4; src1_v = 1'b0;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      found = o_v;
    end
    chk("rg_granted", found, 1);
    step();
    apply_reset();
    step();
    chk("rg_idle_after", o_v, 0);
    step();
    chk("rg_regrant", o_v, 1);
    chk("rg_tag", o_tag, 9);
    arr_a = 1'b1;
    step();
    chk("rg_ack", o_a0, 1);
    arr_a = 1'b0; src0_v = 1'b0;
    $display("reset-in-grant test done");

    // Randomized traffic against the model
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) apply_reset();
      cfg_wr   = ($urandom_range(0, 24) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_data = $urandom;
      if (cfg_addr == 2'd0) cfg_data = (cfg_data & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
      arr_idle = ($urandom_range(0, 4) != 0);
      arr_a    = 1'($urandom_range(0, 1));
      step();
      if (!src0_v || e_a0) begin
        src0_v   = ($urandom_range(0, 2) == 0);
        src0_tag = NF'($urandom);
        src0_ct  = NC'($urandom);
      end
      if (!src1_v || e_a1) begin
        src1_v   = ($urandom_range(0, 2) == 0);
        src1_tag = NF'($urandom);
        src1_ct  = NC'($urandom);
      end
    end
    cfg_wr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_filter_scheduler.md
Name: spike_filter_scheduler

Overview:
Sequences the shared spike filter array datapath.
- Generates the periodic update pulse from a programmable prescaler.
- Round-robin arbitrates two tag/count sources onto the array's single tag/count input.
- Holds the array's configuration registers: period, filts_used, increment and decay constants.
- Guarantees an update pulse is only issued while the array is idle and no tag is being offered, so no pulse is ever dropped.

Parameters:
Nfilts, 10, width of filter tag / filts_used
Nct, 10, width of spike count
Nstate, 27, width of increment/decay constants
Nprescale, 16, width of update period counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
cfg_wr  input  1  config write strobe, single cycle
cfg_addr  input  2  0=period, 1=filts_used, 2=increment_constant, 3=decay_constant
cfg_data  input  32  write data; LSBs used, upper bits ignored
src0_tag / src1_tag  input  Nfilts  source tag
src0_ct / src1_ct  input  Nct  source count
src0_v / src1_v  input  1  source valid; held with data stable until matching _a
src0_a / src1_a  output  1  one-cycle acknowledge
arr_tag  output  Nfilts  tag to array
arr_ct  output  Nct  count to array
arr_v  output  1  valid to array
arr_a  input  1  array acknowledge
arr_idle  input  1  array in READY state
update_pulse  output  1  one-cycle update strobe to array
filts_used  output  Nfilts  registered config
increment_constant  output  Nstate  registered config
decay_constant  output  Nstate  registered config
overrun_cnt  output  16  saturating count of missed update ticks

Behaviour:
- Reset: all outputs 0. Config registers 0 (period 0 = updates disabled). FSM IDLE, pend=0, rr pointer=src0.
- Config: write takes effect the cycle after cfg_wr. A write to period also clears the prescale counter.
- Prescaler (period P≠0):
  - Counter runs 0..P-1; "tick" on the cycle count==P-1, then wraps to 0.
  - Tick sets pend.
  - Tick while pend already 1 → overrun_cnt+1, saturating at 0xFFFF.
  - Tick in the same cycle pend is cleared → pend stays 1, no overrun.
  - P=0: counter held at 0, no ticks; an existing pend is still serviced.
- FSM:
  - IDLE:
    - pend && arr_idle → PULSE; pend cleared. Update has priority over tags.
    - else (src0_v||src1_v) && arr_idle → GRANT. Grant goes to the only valid source; if both are valid, to the source named by the rr pointer. Grant is registered.
    - else stay.
  - PULSE: update_pulse=1 for exactly one cycle, arr_v=0 → SWEEP.
  - SWEEP: wait until arr_idle=1 → IDLE. The array is non-idle from the cycle after PULSE; a sweep stalled by output backpressure simply extends SWEEP.
  - GRANT:
    - arr_v=1; arr_tag/arr_ct are combinational muxes from the granted source.
    - On arr_a=1: granted src_a=1 for that cycle, rr pointer set to the other source, → IDLE.
    - The non-granted source's _a is always 0.
- Outputs: arr_tag/arr_ct are 0 when arr_v=0. update_pulse and arr_v are never asserted in the same cycle.
- Latency:
  - src_v rising in IDLE with array idle → arr_v asserted the next cycle.
  - Pend set in IDLE → update_pulse the next cycle.
- A source dropping _v before _a is a protocol violation: simulation assertion, behaviour undefined.
- Reset mid-GRANT/SWEEP: returns to IDLE; any in-flight source transfer is unacknowledged and must be re-offered.

Optional Feature:
SPIKE_FILTER_OVERRUN_CNT_EN
- Defined: overrun counter implemented as above.
- Undefined: counter logic removed, overrun_cnt tied to 0; ticks while pend=1 are silently merged.

Decomposition:
Shared package spike_filter_pkg holds:
- cfg address constants (CFG_PERIOD=0, CFG_FILTS_USED=1, CFG_INC=2, CFG_DECAY=3)
- the FSM state enum (IDLE, PULSE, SWEEP, GRANT)
- the 16-bit overrun counter width

One sub-module is natural: spike_filter_prescaler (counter, tick, pend, overrun).

Test Plan:
- P=4, no sources, arr_idle=1 → update_pulse every 4 cycles, one cycle wide; overrun_cnt=0.
- src0_v and src1_v held with tags 3 and 7, array acks 2 cycles after arr_v → arr_tag order 3,7,3,7; src_a pulses alternate.
- P=4, arr_idle held 0 for 10 cycles after the first pulse → pend stays set; overrun_cnt=1 or 2 per tick arithmetic; exactly one pulse after arr_idle returns.
- Tick coincident with src0_v in IDLE → update_pulse first, then GRANT to src0 after SWEEP completes.
- Write P=8 mid-count at counter=5 → next tick exactly 8 cycles after the write.
- Reset asserted during GRANT → outputs 0 next cycle; after release, src0 is re-granted with arr_v 1 cycle later.
